// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: battle-screen turn sequencer (menu, attack turns, delays, win/lose/flee outcome).
// Ports: clk_in/rst_in (async active-high) clock and reset; start = game FSM in battle mode;
//   hcount_in/vcount_in pixel position (tick at 0,0); left/right/up/down/select buttons;
//   health_in player HP entering battle; random_num LFSR value.
//   Outputs: health_out/enemy_health HP, *_bar_change health-bar shrink in pixels,
//   cursor_col/cursor_row menu cursor, enemy_sel_x/y sprite select, won, run, state (debug).
// Optional: define CRIT_HIT_EN to enable critical hits on random_num[7:5]==3'b111.
module battle_turn_ctrl #(
  parameter int PLAYER_DAMAGE = 20,
  parameter int ENEMY_DAMAGE  = 10,
  parameter int ENEMY_MAX_HP  = 100,
  parameter int ENEMY_DELAY   = 20,
  parameter int END_DELAY     = 10,
  parameter int BAR_W         = 48
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        left_in,
  input  logic        right_in,
  input  logic        up_in,
  input  logic        down_in,
  input  logic        select,
  input  logic [7:0]  health_in,
  input  logic [7:0]  random_num,
  output logic [7:0]  health_out,
  output logic [7:0]  enemy_health,
  output logic [10:0] player_bar_change,
  output logic [10:0] enemy_bar_change,
  output logic        cursor_col,
  output logic        cursor_row,
  output logic [3:0]  enemy_sel_x,
  output logic        enemy_sel_y,
  output logic        won,
  output logic        run,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE, INIT, MENU, PLAYER_ATK, ENEMY_WAIT, ENEMY_ATK, END_WAIT, DONE} state_t;
  localparam logic [10:0] BW = 11'(BAR_W);
  localparam logic [7:0]  ED = 8'(ENEMY_DAMAGE);
  state_t st;
  logic [15:0] counter;
  logic tick;
  logic [7:0] p_dmg, e_hp_nx, p_hp_nx;
  logic [10:0] p_inc, e_bar_sum, e_bar_nx, p_bar_sum, p_bar_nx;
  assign tick = hcount_in == '0 && vcount_in == '0;
  assign state = st;
`ifdef CRIT_HIT_EN
  logic crit;
  assign crit  = random_num[7:5] == 3'b111;
  assign p_dmg = crit ? 8'(2 * PLAYER_DAMAGE) : 8'(PLAYER_DAMAGE);
  assign p_inc = crit ? 11'(PLAYER_DAMAGE) : 11'(PLAYER_DAMAGE / 2);
`else
  logic unused_rnd;
  assign unused_rnd = ^random_num[7:5];
  assign p_dmg = 8'(PLAYER_DAMAGE);
  assign p_inc = 11'(PLAYER_DAMAGE / 2);
`endif
  assign e_hp_nx   = enemy_health > p_dmg ? enemy_health - p_dmg : '0;
  assign e_bar_sum = enemy_bar_change + p_inc;
  assign e_bar_nx  = e_bar_sum > BW ? BW : e_bar_sum;
  assign p_hp_nx   = health_out > ED ? health_out - ED : '0;
  assign p_bar_sum = player_bar_change + 11'(ENEMY_DAMAGE / 2);
  assign p_bar_nx  = p_bar_sum > BW ? BW : p_bar_sum;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st <= IDLE;
      counter <= '0;
      health_out <= '0;
      enemy_health <= '0;
      player_bar_change <= '0;
      enemy_bar_change <= '0;
      cursor_col <= 1'b0;
      cursor_row <= 1'b0;
      enemy_sel_x <= '0;
      enemy_sel_y <= 1'b0;
      won <= 1'b0;
      run <= 1'b0;
    end else if (st != IDLE && !start) begin
      // abort back to the overworld: HP and bars deliberately hold
      st <= IDLE;
      run <= 1'b0;
      won <= 1'b0;
    end else if (tick) begin
      case (st)
        IDLE: begin
          run <= 1'b0;
          won <= 1'b0;
          if (start) st <= INIT;
        end
        INIT: begin
          enemy_health <= 8'(ENEMY_MAX_HP);
          health_out <= health_in;
          player_bar_change <= '0;
          enemy_bar_change <= '0;
          counter <= '0;
          cursor_col <= 1'b0;
          cursor_row <= 1'b0;
          enemy_sel_x <= &random_num[3:0] ? 4'd14 : random_num[3:0];
          enemy_sel_y <= random_num[4];
          st <= health_in == '0 ? END_WAIT : MENU;
        end
        MENU: begin
          cursor_col <= left_in ? 1'b0 : right_in ? 1'b1 : cursor_col;
          cursor_row <= up_in ? 1'b0 : down_in ? 1'b1 : cursor_row;
          // select acts on the cursor as it was before this tick's move
          if (select && !cursor_col && !cursor_row) st <= PLAYER_ATK;
          else if (select && cursor_col && cursor_row) begin
            st <= DONE;
            run <= 1'b1;
            won <= 1'b0;
          end
        end
        PLAYER_ATK: begin
          enemy_health <= e_hp_nx;
          enemy_bar_change <= e_bar_nx;
          counter <= '0;
          won <= e_hp_nx == '0;
          st <= e_hp_nx == '0 ? END_WAIT : ENEMY_WAIT;
        end
        ENEMY_WAIT: begin
          counter <= counter == 16'(ENEMY_DELAY - 1) ? '0 : counter + 16'd1;
          if (counter == 16'(ENEMY_DELAY - 1)) st <= ENEMY_ATK;
        end
        ENEMY_ATK: begin
          health_out <= p_hp_nx;
          player_bar_change <= p_bar_nx;
          counter <= '0;
          st <= p_hp_nx == '0 ? END_WAIT : MENU;
        end
        END_WAIT: begin
          counter <= counter == 16'(END_DELAY - 1) ? '0 : counter + 16'd1;
          if (counter == 16'(END_DELAY - 1)) begin
            st <= DONE;
            run <= 1'b1;
          end
        end
        DONE: run <= 1'b1;
      endcase
    end
  end
endmodule

// File: doc/battle_turn_ctrl.md
Name: battle_turn_ctrl

Overview:
Turn sequencer for the battle screen. Owns the battle state machine: encounter init, menu cursor, player/enemy attack turns, inter-turn delays, win/lose/flee outcome. Drives HP values, health-bar shrink amounts, cursor position and enemy sprite select consumed by the battle renderer. Sits between the overworld game FSM (start/run handshake) and the battle pixel datapath.

Parameters:
PLAYER_DAMAGE, 20, HP removed from enemy per player attack
ENEMY_DAMAGE, 10, HP removed from player per enemy attack
ENEMY_MAX_HP, 100, enemy HP loaded at encounter init
ENEMY_DELAY, 20, frames in ENEMY_WAIT before the enemy attacks (>=1)
END_DELAY, 10, frames in END_WAIT before run asserts (>=1)
BAR_W, 48, health-bar width in pixels; saturation limit for bar change

Ports:
clk_in  in  1  pixel clock; the only clock
rst_in  in  1  reset, asynchronous, active-high
start  in  1  level; high while the game FSM is in battle mode
hcount_in  in  11  current pixel x
vcount_in  in  10  current pixel y
left_in, right_in, up_in, down_in, select  in  1 each  debounced buttons
health_in  in  8  player HP entering battle
random_num  in  8  free-running LFSR value
health_out  out  8  player HP
enemy_health  out  8  enemy HP
player_bar_change  out  11  pixels removed from player bar
enemy_bar_change  out  11  pixels removed from enemy bar
cursor_col  out  1  0=FIGHT column, 1=RUN column
cursor_row  out  1  0=top row, 1=bottom row
enemy_sel_x  out  4  enemy sprite column
enemy_sel_y  out  1  enemy sprite row
won  out  1  high once the enemy reaches 0 HP, held until IDLE
run  out  1  high in DONE: battle over, hand back to overworld
state  out  3  current state encoding (debug)

Behaviour:
- tick = (hcount_in==0 && vcount_in==0), combinational. All transitions except abort happen only on clock edges where tick=1.
- Async reset: state=IDLE; all outputs 0; counter=0.
- Abort: start=0 in any state other than IDLE -> IDLE on the next clock edge, not tick-gated. run and won clear; HP and bar outputs hold.
- IDLE (0): run=0, won=0. start=1 && tick -> INIT.
- INIT (1), one tick:
  - enemy_health=ENEMY_MAX_HP; health_out=health_in; both bar changes=0; counter=0; cursor=(0,0).
  - enemy_sel_x=random_num[3:0], clamped to 14 if 15; enemy_sel_y=random_num[4].
  - health_in==0 -> END_WAIT (loss); else -> MENU.
- MENU (2), per tick:
  - Cursor moves: left->col 0, right->col 1, up->row 0, down->row 1. left beats right; up beats down.
  - select is decoded against the pre-move cursor: (0,0) -> PLAYER_ATK; (1,1) -> DONE (flee, won=0); other positions ignored.
- PLAYER_ATK (3), one tick:
  - enemy_health = max(enemy_health-PLAYER_DAMAGE, 0).
  - enemy_bar_change = min(enemy_bar_change+PLAYER_DAMAGE/2, BAR_W).
  - Next: result 0 -> END_WAIT, won=1; else -> ENEMY_WAIT, counter=0.
- ENEMY_WAIT (4): counter++ per tick; counter==ENEMY_DELAY-1 -> ENEMY_ATK, counter=0.
- ENEMY_ATK (5), one tick:
  - Saturating subtract of ENEMY_DAMAGE from health_out; player_bar_change saturates the same way.
  - Next: result 0 -> END_WAIT; else -> MENU.
- END_WAIT (6): counter++ per tick; counter==END_DELAY-1 -> DONE, counter=0.
- DONE (7): run=1 held. Leaves only via abort (start=0). Re-entering a battle needs start low for at least one clock.
- Arithmetic: all subtracts are 8-bit saturating at 0, never wrap. Bar sums use 11 bits and clamp at BAR_W.
- Output latency: every output is registered and visible the clock after the tick edge that caused it.

Optional Feature:
CRIT_HIT_EN
- Defined: in PLAYER_ATK, if random_num[7:5]==3'b111, damage is 2*PLAYER_DAMAGE and bar change is PLAYER_DAMAGE, both with the same saturation.
- Undefined: damage is always PLAYER_DAMAGE; random_num[7:5] is unused.

Test Plan:
- Reset mid-ENEMY_WAIT (counter=7) -> next cycle state=0, all outputs 0, run=0.
- start=1, health_in=100; select on FIGHT on every MENU visit -> enemy 100/80/60/40/20/0; health_out ends 60; enemy_bar_change clamps at 48; won=1; run rises END_DELAY(10) ticks after the 5th attack.
- health_in=25, no crits; select FIGHT each time -> health_out 15, 5, then 0 (saturates, no wrap), enemy at 40; won=0; END_WAIT then DONE.
- MENU: press right+down, then select -> DONE, run=1, won=0, enemy_health=100. Cursor at (1,0) with select -> stays in MENU.
- left+right together -> cursor_col=0. Button held between ticks -> no state change until the tick.
- random_num=8'hEF at INIT -> enemy_sel_x=14, enemy_sel_y=0. With CRIT_HIT_EN and random_num[7:5]=7 at PLAYER_ATK -> enemy 100->60, bar change 20. start dropped in MENU -> IDLE next clock.
